// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operation sequencer.
//   - datapath widths (register count, op code width, default counter width)
//   - op codes the sequencer treats specially (wide MUL/DIV, unary NEG/NOT)
//   - state encoding for the sequencer FSM
//   - helpers is_unary() / is_wide() used for branch decisions
package alu_op_pkg;

    localparam int NREGS    = 16;
    localparam int OPW      = 5;
    localparam int CNTW_DEF = 16;

    localparam logic [OPW-1:0] OP_ADD = 5'd3;
    localparam logic [OPW-1:0] OP_MUL = 5'd14;
    localparam logic [OPW-1:0] OP_DIV = 5'd15;
    localparam logic [OPW-1:0] OP_NEG = 5'd16;
    localparam logic [OPW-1:0] OP_NOT = 5'd17;

    typedef logic [2:0] state_t;

    localparam state_t IDLE    = 3'd0;
    localparam state_t T1_LDY  = 3'd1;
    localparam state_t T2_ALU  = 3'd2;
    localparam state_t T3_WRLO = 3'd3;
    localparam state_t T4_WRHI = 3'd4;

    // Unary ops skip the Y load; the single operand arrives in T2_ALU.
    function automatic logic is_unary(input logic [OPW-1:0] op);
        return (op == OP_NEG) || (op == OP_NOT);
    endfunction

    // Wide ops produce a 64-bit result that goes to HI/LO, not a general register.
    function automatic logic is_wide(input logic [OPW-1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request/strobe bundle between the decode (master) and the sequencer (slave).
//   master drives: req, op_in, ra, rb, rc
//   slave drives : busy, done, r_out, r_in, y_in, zlow_in, zhigh_in,
//                  zlow_out, zhigh_out, hi_in, lo_in, alu_op, op_count
interface alu_op_sequencer_if
    import alu_op_pkg::*;
#(
    parameter int CNTW = CNTW_DEF
);
    logic             req;
    logic [OPW-1:0]   op_in;
    logic [3:0]       ra;
    logic [3:0]       rb;
    logic [3:0]       rc;

    logic             busy;
    logic             done;
    logic [NREGS-1:0] r_out;
    logic [NREGS-1:0] r_in;
    logic             y_in;
    logic             zlow_in;
    logic             zhigh_in;
    logic             zlow_out;
    logic             zhigh_out;
    logic             hi_in;
    logic             lo_in;
    logic [OPW-1:0]   alu_op;
    logic [CNTW-1:0]  op_count;

    modport master (
        output req, op_in, ra, rb, rc,
        input  busy, done, r_out, r_in, y_in, zlow_in, zhigh_in,
               zlow_out, zhigh_out, hi_in, lo_in, alu_op, op_count
    );

    modport slave (
        input  req, op_in, ra, rb, rc,
        output busy, done, r_out, r_in, y_in, zlow_in, zhigh_in,
               zlow_out, zhigh_out, hi_in, lo_in, alu_op, op_count
    );

endinterface

// File: rtl/alu_op_sequencer_dec.sv
// onehot_dec16: 4-bit index plus enable to 16-bit one-hot strobe vector.
//   i_idx    : register index
//   i_en     : 0 forces the output to all zeros
//   o_onehot : bit i_idx set when enabled
module onehot_dec16 (
    input  logic [3:0]  i_idx,
    input  logic        i_en,
    output logic [15:0] o_onehot
);

    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            o_onehot[i_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: steps one register-register ALU request through the
// shared-bus datapath, emitting the per-cycle bus-out / register-in strobes.
//   clock : rising-edge clock
//   clear : asynchronous active-high reset
//   bus   : alu_op_sequencer_if.slave (request fields in, strobes/status out)
// Build option: OPSEQ_OP_COUNT_EN adds the completed-operation counter;
// without it op_count is tied to zero and sequencing is unchanged.
//
//   state   | meaning
//   IDLE    | waiting for req; all strobes low
//   T1_LDY  | R[rb] -> bus, load Y
//   T2_ALU  | R[rc] -> bus, load Z (hi/lo)
//   T3_WRLO | Zlow -> bus; write R[ra] and finish, or load LO for wide ops
//   T4_WRHI | Zhigh -> bus, load HI, finish (MUL/DIV only)
module alu_op_sequencer
    import alu_op_pkg::*;
#(
    parameter int CNTW = CNTW_DEF
) (
    input  logic             clock,
    input  logic             clear,
    alu_op_sequencer_if.slave bus
);

    state_t         r_state;
    logic [OPW-1:0] r_op;
    logic [3:0]     r_ra;
    logic [3:0]     r_rb;
    logic [3:0]     r_rc;

    logic           w_wide;
    logic           w_done;
    logic           w_rout_en;
    logic [3:0]     w_rout_idx;
    logic           w_rin_en;
    logic [15:0]    w_rout;
    logic [15:0]    w_rin;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state <= IDLE;
            r_op    <= '0;
            r_ra    <= '0;
            r_rb    <= '0;
            r_rc    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req) begin
                        r_op    <= bus.op_in;
                        r_ra    <= bus.ra;
                        r_rb    <= bus.rb;
                        r_rc    <= bus.rc;
                        r_state <= is_unary(bus.op_in) ? T2_ALU : T1_LDY;
                    end
                end
                T1_LDY:  r_state <= T2_ALU;
                T2_ALU:  r_state <= T3_WRLO;
                T3_WRLO: r_state <= w_wide ? T4_WRHI : IDLE;
                T4_WRHI: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_wide     = is_wide(r_op);
    assign w_done     = ((r_state == T3_WRLO) && !w_wide) || (r_state == T4_WRHI);

    assign w_rout_en  = (r_state == T1_LDY) || (r_state == T2_ALU);
    assign w_rout_idx = (r_state == T1_LDY) ? r_rb : r_rc;
    assign w_rin_en   = (r_state == T3_WRLO) && !w_wide;

    onehot_dec16 u_dec_rout (
        .i_idx    (w_rout_idx),
        .i_en     (w_rout_en),
        .o_onehot (w_rout)
    );

    onehot_dec16 u_dec_rin (
        .i_idx    (r_ra),
        .i_en     (w_rin_en),
        .o_onehot (w_rin)
    );

    assign bus.r_out     = w_rout;
    assign bus.r_in      = w_rin;
    assign bus.y_in      = (r_state == T1_LDY);
    assign bus.zlow_in   = (r_state == T2_ALU);
    assign bus.zhigh_in  = (r_state == T2_ALU);
    assign bus.zlow_out  = (r_state == T3_WRLO);
    assign bus.lo_in     = (r_state == T3_WRLO) && w_wide;
    assign bus.zhigh_out = (r_state == T4_WRHI);
    assign bus.hi_in     = (r_state == T4_WRHI);
    assign bus.done      = w_done;
    assign bus.busy      = (r_state != IDLE);
    // The latched op register survives into IDLE; mask it so IDLE shows 0.
    assign bus.alu_op    = (r_state != IDLE) ? r_op : '0;

`ifdef OPSEQ_OP_COUNT_EN
    logic [CNTW-1:0] r_count;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_count <= '0;
        end else if (w_done) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign bus.op_count = r_count;
`else
    assign bus.op_count = {CNTW{1'b0}};
`endif

endmodule
